regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised successor to the 8x16 datapath register file: WIDTH x DEPTH storage, one synchronous write port, two independent combinational read ports (A and B).
- Adds a runtime clear sequencer. On request it zeroes the file one entry per cycle, with busy/done status.
- Sits in the datapath between the writeback mux and the ALU A/B operand loads.

Parameters:
- WIDTH, 16, data width in bits.
- DEPTH, 8, number of registers; must satisfy 2 <= DEPTH <= 2**AW.
- AW, 3, width of register-number fields.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- data_in, input, WIDTH, write data.
- writenum, input, AW, write register number.
- write, input, 1, write enable.
- readnum_a, input, AW, read port A register number.
- readnum_b, input, AW, read port B register number.
- data_out_a, output, WIDTH, read port A data.
- data_out_b, output, WIDTH, read port B data.
- clear_req, input, 1, start clear sequence (level-sampled).
- busy, output, 1, clear sequence in progress.
- clear_done, output, 1, one-cycle pulse after the last entry is cleared.
- write_drop, output, 1, one-cycle pulse: a write was discarded.

Behaviour:
- Reset: rst_n low asynchronously forces:
  - all DEPTH entries to 0;
  - FSM to IDLE, clear pointer to 0;
  - busy, clear_done and write_drop to 0.
  - Reset mid-clear aborts the sequence; no clear_done is produced.
- Reads: combinational from storage. data_out_x = reg[readnum_x] when readnum_x < DEPTH, else 0. The two ports are fully independent and may address the same register.
- Write: at posedge, if write=1, busy=0 and writenum < DEPTH, then reg[writenum] <= data_in.
  - writenum >= DEPTH: write ignored, write_drop pulses the next cycle.
  - Write while busy=1: write ignored, write_drop pulses.
- FSM states:
  - IDLE: busy=0. clear_req=1 at posedge -> CLEAR with ptr=0. A write in the same cycle as clear_req is performed (and later zeroed by the sequence).
  - CLEAR: busy=1. Each cycle reg[ptr] <= 0 and ptr increments. On the cycle ptr=DEPTH-1 the entry is cleared, the FSM returns to IDLE and clear_done is registered high for the next cycle.
  - Clear duration is exactly DEPTH cycles; busy is high for DEPTH cycles.
  - clear_req while in CLEAR is ignored (no restart).
  - clear_req held high across the return to IDLE starts a new sequence on the following posedge.
- Reads during CLEAR return current contents: entries with index < ptr already read 0.
- Outputs busy, clear_done and write_drop are registered; data_out_a/b are combinational.
- Write latency: new data is visible on read ports the cycle after the write edge, unless the bypass feature is enabled.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through forwarding. If write=1, busy=0, writenum < DEPTH and readnum_x == writenum, then data_out_x = data_in combinationally in the same cycle. Applies independently to ports A and B.
- Not defined: reads return the stored value; the written value appears after the clock edge.

Test Plan:
- Reset/clear: assert rst_n=0 mid-cycle after loading reg3=16'hBEEF -> both ports read 0 for every readnum immediately (asynchronous clear); busy=0.
- Write/dual read: write R2=16'h1234 and R5=16'hA5A5; readnum_a=2, readnum_b=5 -> data_out_a=16'h1234, data_out_b=16'hA5A5. Then set readnum_a=readnum_b=5 -> both read 16'hA5A5.
- Clear sequence: fill R0..R7=16'h0101*(i+1), pulse clear_req -> busy high exactly 8 cycles. After 3 cycles R0..R2 read 0 and R3 reads 16'h0404. clear_done pulses once; all entries read 0.
- Write during clear: write R6=16'hFFFF on the 2nd busy cycle -> write_drop pulses one cycle later; R6 reads 0 after clear_done.
- Out-of-range access (DEPTH=6, AW=3): write writenum=7 -> write_drop=1, no entry changes; readnum_a=6 -> data_out_a=0.
- Bypass (RF_BYPASS_EN defined): write R1=16'h00C3 with readnum_a=1 -> data_out_a=16'h00C3 in the same cycle. Without the macro -> old value that cycle, 16'h00C3 the next cycle.

Source files
------------

// File: rtl/regfile_2r1w.sv
// WIDTH x DEPTH register file: one synchronous write port, two combinational read ports,
// plus a one-entry-per-cycle clear sequencer. Define RF_BYPASS_EN for write-through reads.
module regfile_2r1w #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    writenum,
    input  logic             write,
    input  logic [AW-1:0]    readnum_a,
    input  logic [AW-1:0]    readnum_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    input  logic             clear_req,
    output logic             busy,
    output logic             clear_done,
    output logic             write_drop
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             clear_done_q, clear_done_d;
    logic             write_drop_q, write_drop_d;
    logic             wr_in_range_s;
    logic             wr_ok_s;
    logic [WIDTH-1:0] rd_a_s, rd_b_s;

    assign wr_in_range_s = ({1'b0, writenum} < (AW+1)'(DEPTH));
    // busy_q mirrors the CLEAR state, so writes are blocked for the whole sequence
    assign wr_ok_s       = write & ~busy_q & wr_in_range_s;

    // Read muxes: out-of-range register numbers fall through to zero
    always_comb begin
        rd_a_s = {WIDTH{1'b0}};
        rd_b_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rd_a_s = (readnum_a == AW'(i)) ? mem_q[i] : rd_a_s;
            rd_b_s = (readnum_b == AW'(i)) ? mem_q[i] : rd_b_s;
        end
`ifdef RF_BYPASS_EN
        rd_a_s = (wr_ok_s && (readnum_a == writenum)) ? data_in : rd_a_s;
        rd_b_s = (wr_ok_s && (readnum_b == writenum)) ? data_in : rd_b_s;
`else
        rd_a_s = rd_a_s;
        rd_b_s = rd_b_s;
`endif
    end

    // Next-state for storage, clear sequencer and status pulses
    always_comb begin
        mem_d        = mem_q;
        state_d      = state_q;
        ptr_d        = ptr_q;
        clear_done_d = 1'b0;
        write_drop_d = write & ~wr_ok_s;
        case (state_q)
            ST_IDLE: begin
                // A write coexisting with clear_req lands now and is wiped by the sequence
                for (int i = 0; i < DEPTH; i++) begin
                    mem_d[i] = (wr_ok_s && (writenum == AW'(i))) ? data_in : mem_q[i];
                end
                state_d = clear_req ? ST_CLEAR : ST_IDLE;
                ptr_d   = {AW{1'b0}};
            end
            ST_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_d[i] = (ptr_q == AW'(i)) ? {WIDTH{1'b0}} : mem_q[i];
                end
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d      = ST_IDLE;
                    ptr_d        = {AW{1'b0}};
                    clear_done_d = 1'b1;
                end else begin
                    state_d      = ST_CLEAR;
                    ptr_d        = ptr_q + AW'(1);
                    clear_done_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = {AW{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // State registers with asynchronous reset; reset mid-clear simply abandons the sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            state_q      <= ST_IDLE;
            ptr_q        <= {AW{1'b0}};
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            write_drop_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            write_drop_q <= write_drop_d;
        end
    end

    assign data_out_a = rd_a_s;
    assign data_out_b = rd_b_s;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign write_drop = write_drop_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: an 8-entry and a 6-entry instance checked against an array model.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [2:0]  writenum, readnum_a, readnum_b;
    logic        write, clear_req;
    logic [15:0] data_out_a, data_out_b;
    logic        busy, clear_done, write_drop;

    logic [15:0] d6_in;
    logic [2:0]  wn6, ra6, rb6;
    logic        w6, clr6;
    logic [15:0] doa6, dob6;
    logic        busy6, done6, drop6;

    int total = 0;
    int bad   = 0;

    logic [15:0] m8 [8];
    logic [15:0] m6 [6];
    int          clr_left;
    logic        exp_done8, exp_drop8, exp_drop6;
    int          busy_cnt, done_cnt;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum), .write(write),
        .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(data_out_a),
        .data_out_b(data_out_b), .clear_req(clear_req), .busy(busy),
        .clear_done(clear_done), .write_drop(write_drop)
    );

    regfile_2r1w #(.WIDTH(16), .DEPTH(6), .AW(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .data_in(d6_in), .writenum(wn6), .write(w6),
        .readnum_a(ra6), .readnum_b(rb6), .data_out_a(doa6), .data_out_b(dob6),
        .clear_req(clr6), .busy(busy6), .clear_done(done6), .write_drop(drop6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd8(input logic [2:0] rn);
`ifdef RF_BYPASS_EN
        if (write && clr_left == 0 && rn == writenum) return data_in;
`endif
        return m8[int'(rn)];
    endfunction

    function automatic logic [15:0] exp_rd6(input logic [2:0] rn);
`ifdef RF_BYPASS_EN
        if (w6 && wn6 < 3'd6 && rn == wn6) return d6_in;
`endif
        if (rn < 3'd6) return m6[int'(rn)];
        return 16'h0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m8[i] = 16'h0000;
        for (int i = 0; i < 6; i++) m6[i] = 16'h0000;
        clr_left = 0;
    endtask

    task automatic check_reads(input string tag);
        #1;
        chk({tag, "_a"},  data_out_a, exp_rd8(readnum_a));
        chk({tag, "_b"},  data_out_b, exp_rd8(readnum_b));
        chk({tag, "_a6"}, doa6, exp_rd6(ra6));
        chk({tag, "_b6"}, dob6, exp_rd6(rb6));
    endtask

    // Advance one clock edge, updating the model from the current inputs, then check status
    task automatic tick();
        bit was_busy;
        was_busy  = (clr_left > 0);
        exp_drop8 = write && was_busy;
        if (!was_busy && write) m8[int'(writenum)] = data_in;
        exp_done8 = 1'b0;
        if (was_busy) begin
            m8[8 - clr_left] = 16'h0000;
            clr_left--;
            if (clr_left == 0) exp_done8 = 1'b1;
        end else if (clear_req) begin
            clr_left = 8;
        end
        exp_drop6 = w6 && (wn6 >= 3'd6);
        if (w6 && wn6 < 3'd6) m6[int'(wn6)] = d6_in;
        @(posedge clk);
        #1;
        chk("busy",       busy,       (clr_left > 0));
        chk("clear_done", clear_done, exp_done8);
        chk("write_drop", write_drop, exp_drop8);
        chk("busy6",      busy6,      1'b0);
        chk("done6",      done6,      1'b0);
        chk("drop6",      drop6,      exp_drop6);
    endtask

    task automatic async_reset_check();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        write = 1'b0; w6 = 1'b0; clear_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            readnum_a = 3'(2 * i); readnum_b = 3'(2 * i + 1);
            ra6 = 3'(2 * i); rb6 = 3'(2 * i + 1);
            #0.2;
            chk("rst_rd_a", data_out_a, 16'h0000);
            chk("rst_rd_b", data_out_b, 16'h0000);
            chk("rst_rd_a6", doa6, 16'h0000);
            chk("rst_rd_b6", dob6, 16'h0000);
        end
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", clear_done, 1'b0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; data_in = 16'h0000; writenum = 3'd0; write = 1'b0;
        readnum_a = 3'd0; readnum_b = 3'd0; clear_req = 1'b0;
        d6_in = 16'h0000; wn6 = 3'd0; w6 = 1'b0; ra6 = 3'd0; rb6 = 3'd0; clr6 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy", busy, 1'b0);
        chk("init_drop", write_drop, 1'b0);
        rst_n = 1'b1;
        check_reads("init");

        // Load R3 then reset asynchronously mid-cycle
        write = 1'b1; writenum = 3'd3; data_in = 16'hBEEF;
        tick();
        write = 1'b0; readnum_a = 3'd3;
        check_reads("r3");
        chk("r3_beef", data_out_a, 16'hBEEF);
        async_reset_check();

        // Dual-port reads
        write = 1'b1; writenum = 3'd2; data_in = 16'h1234; tick();
        writenum = 3'd5; data_in = 16'hA5A5; tick();
        write = 1'b0; readnum_a = 3'd2; readnum_b = 3'd5;
        check_reads("dual");
        chk("dual_a", data_out_a, 16'h1234);
        chk("dual_b", data_out_b, 16'hA5A5);
        readnum_a = 3'd5;
        check_reads("same");
        chk("same_a", data_out_a, 16'hA5A5);
        chk("same_b", data_out_b, 16'hA5A5);

        // Fill, clear, write R6 on the second busy cycle
        write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            writenum = 3'(i); data_in = 16'(16'h0101 * (i + 1));
            tick();
        end
        write = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        busy_cnt = busy ? 1 : 0; done_cnt = 0;
        tick();
        busy_cnt += busy ? 1 : 0;
        write = 1'b1; writenum = 3'd6; data_in = 16'hFFFF;
        tick();
        busy_cnt += busy ? 1 : 0;
        chk("drop_in_clear", write_drop, 1'b1);
        write = 1'b0;
        tick();
        busy_cnt += busy ? 1 : 0;
        readnum_a = 3'd3; readnum_b = 3'd2;
        check_reads("mid3");
        chk("mid_r3", data_out_a, 16'h0404);
        chk("mid_r2", data_out_b, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            tick();
            busy_cnt += busy ? 1 : 0;
            done_cnt += clear_done ? 1 : 0;
        end
        chk("busy_len", 32'(busy_cnt), 32'd8);
        chk("done_cnt", 32'(done_cnt), 32'd1);
        readnum_a = 3'd6; readnum_b = 3'd7;
        check_reads("post");
        chk("post_r6", data_out_a, 16'h0000);

        // Held clear_req restarts; then reset mid-clear
        clear_req = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        clear_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        tick(); tick();
        async_reset_check();
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            done_cnt += clear_done ? 1 : 0;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Out-of-range on the 6-entry instance
        w6 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wn6 = 3'(i); d6_in = 16'($urandom);
            tick();
        end
        wn6 = 3'd7; d6_in = 16'hDEAD; tick();
        chk("oor_drop7", drop6, 1'b1);
        wn6 = 3'd6; tick();
        w6 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra6 = 3'(2 * i); rb6 = 3'(2 * i + 1);
            check_reads("oor");
        end
        ra6 = 3'd6;
        check_reads("oor6");
        chk("oor_rd6", doa6, 16'h0000);

        // Same-cycle read of a register being written
        write = 1'b1; writenum = 3'd1; data_in = 16'h1111; tick();
        data_in = 16'h00C3; readnum_a = 3'd1;
        check_reads("byp");
`ifdef RF_BYPASS_EN
        chk("byp_same", data_out_a, 16'h00C3);
`else
        chk("byp_same", data_out_a, 16'h1111);
`endif
        tick();
        write = 1'b0;
        check_reads("byp_next");
        chk("byp_next", data_out_a, 16'h00C3);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            write     = 1'($urandom);
            writenum  = 3'($urandom);
            data_in   = 16'($urandom);
            readnum_a = 3'($urandom);
            readnum_b = ($urandom_range(0, 3) == 0) ? writenum : 3'($urandom);
            clear_req = ($urandom_range(0, 15) == 0);
            w6        = 1'($urandom);
            wn6       = 3'($urandom);
            d6_in     = 16'($urandom);
            ra6       = ($urandom_range(0, 3) == 0) ? wn6 : 3'($urandom);
            rb6       = 3'($urandom);
            check_reads("rnd");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
